cpu_mem_arbiter: RTL and testbench

//   Shares one single-port instruction/data memory between the CPU fetch port (IF) and the

---
 rtl/cpu_mem_pkg.sv | 19 +
 rtl/mem_arb_streak.sv | 36 +++
 rtl/cpu_mem_arbiter.sv | 165 ++++++++++++++++
 tb/tb_cpu_mem_arbiter.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_mem_pkg.sv
// Shared types for the CPU/memory arbiter: default widths, FSM states and grant owners.
package cpu_mem_pkg;

   localparam int DEF_ADDR_W = 32;
   localparam int DEF_DATA_W = 32;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_e;

   typedef enum logic {
      GNT_IF = 1'b0,
      GNT_D  = 1'b1
   } gnt_e;

endpackage

// File: rtl/mem_arb_streak.sv
// Winner select between fetch and data ports, with a saturating count of back-to-back
// data grants so fetch cannot be starved.
module mem_arb_streak #(
   parameter int MAX_DSTREAK = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic i_if_req,
   input  logic i_d_req,
   input  logic i_grant,
   output logic o_win_d
);

   localparam int SW = $clog2(MAX_DSTREAK + 1);
   localparam logic [SW-1:0] SMAX = SW'(MAX_DSTREAK);

   logic [SW-1:0] r_streak;
   logic          w_force_if;

   always_comb begin
      w_force_if = (r_streak == SMAX) && i_if_req;
      o_win_d    = i_d_req && !w_force_if;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_streak <= '0;
      end else if (i_grant) begin
         if (!o_win_d)
            r_streak <= '0;
         else if (r_streak != SMAX)
            r_streak <= r_streak + 1'b1;
      end
   end

endmodule

// File: rtl/cpu_mem_arbiter.sv
// Single-port memory arbiter between CPU fetch (IF) and load/store (D): one access per
// grant, fixed read latency, registered one-cycle completion pulses.
module cpu_mem_arbiter
   import cpu_mem_pkg::*;
#(
   parameter int ADDR_W      = DEF_ADDR_W,
   parameter int DATA_W      = DEF_DATA_W,
   parameter int MEM_LAT     = 1,
   parameter int MAX_DSTREAK = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                halt,
   input  logic                if_req,
   input  logic [ADDR_W-1:0]   if_addr,
   output logic [DATA_W-1:0]   if_rdata,
   output logic                if_valid,
   input  logic                d_req,
   input  logic                d_we,
   input  logic [DATA_W/8-1:0] d_be,
   input  logic [ADDR_W-1:0]   d_addr,
   input  logic [DATA_W-1:0]   d_wdata,
   output logic [DATA_W-1:0]   d_rdata,
   output logic                d_valid,
   output logic                mem_en,
   output logic                mem_we,
   output logic [DATA_W/8-1:0] mem_be,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   input  logic [DATA_W-1:0]   mem_rdata,
   output logic                busy
);

   localparam int BE_W = DATA_W / 8;
   localparam logic [2:0] LAT_M1 = 3'(MEM_LAT - 1);

   state_e            r_state, w_state;
   gnt_e              r_own, w_own;
   logic [2:0]        r_cnt, w_cnt;
   logic              r_mem_en, w_mem_en;
   logic              r_mem_we, w_mem_we;
   logic [BE_W-1:0]   r_mem_be, w_mem_be;
   logic [ADDR_W-1:0] r_mem_addr, w_mem_addr;
   logic [DATA_W-1:0] r_mem_wdata, w_mem_wdata;
   logic [DATA_W-1:0] r_if_rdata, w_if_rdata;
   logic              r_if_valid, w_if_valid;
   logic [DATA_W-1:0] r_d_rdata, w_d_rdata;
   logic              r_d_valid, w_d_valid;
   logic              r_busy;
   logic              w_grant;
   logic              w_win_d;

   mem_arb_streak #(
      .MAX_DSTREAK (MAX_DSTREAK)
   ) u_streak (
      .clk      (clk),
      .reset    (reset),
      .i_if_req (if_req),
      .i_d_req  (d_req),
      .i_grant  (w_grant),
      .o_win_d  (w_win_d)
   );

   // Next-state and next-output logic; every output is registered from these values.
   always_comb begin
      w_state     = r_state;
      w_own       = r_own;
      w_cnt       = r_cnt;
      w_grant     = 1'b0;
      w_mem_en    = 1'b0;
      w_mem_we    = 1'b0;
      w_mem_be    = r_mem_be;
      w_mem_addr  = r_mem_addr;
      w_mem_wdata = r_mem_wdata;
      w_if_rdata  = r_if_rdata;
      w_if_valid  = 1'b0;
      w_d_rdata   = r_d_rdata;
      w_d_valid   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (!halt && (if_req || d_req)) begin
               w_grant  = 1'b1;
               w_state  = ST_ISSUE;
               w_mem_en = 1'b1;
               if (w_win_d) begin
                  w_own       = GNT_D;
                  w_mem_we    = d_we;
                  w_mem_be    = d_be;
                  w_mem_addr  = d_addr;
                  w_mem_wdata = d_wdata;
               end else begin
                  w_own      = GNT_IF;
                  w_mem_be   = '1;
                  w_mem_addr = if_addr;
               end
            end
         end
         ST_ISSUE: begin
            w_state = ST_WAIT;
            w_cnt   = LAT_M1;
         end
         ST_WAIT: begin
            // Last wait cycle is exactly when the memory presents the read word.
            if (r_cnt == 3'd0) begin
               w_state = ST_RESP;
               if (r_own == GNT_D) begin
                  w_d_rdata = mem_rdata;
                  w_d_valid = 1'b1;
               end else begin
                  w_if_rdata = mem_rdata;
                  w_if_valid = 1'b1;
               end
            end else begin
               w_cnt = r_cnt - 3'd1;
            end
         end
         ST_RESP: w_state = ST_IDLE;
         default: w_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_own       <= GNT_IF;
         r_cnt       <= 3'd0;
         r_mem_en    <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_be    <= '0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_if_rdata  <= '0;
         r_if_valid  <= 1'b0;
         r_d_rdata   <= '0;
         r_d_valid   <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_state     <= w_state;
         r_own       <= w_own;
         r_cnt       <= w_cnt;
         r_mem_en    <= w_mem_en;
         r_mem_we    <= w_mem_we;
         r_mem_be    <= w_mem_be;
         r_mem_addr  <= w_mem_addr;
         r_mem_wdata <= w_mem_wdata;
         r_if_rdata  <= w_if_rdata;
         r_if_valid  <= w_if_valid;
         r_d_rdata   <= w_d_rdata;
         r_d_valid   <= w_d_valid;
         r_busy      <= (w_state != ST_IDLE);
      end
   end

   assign mem_en    = r_mem_en;
   assign mem_we    = r_mem_we;
   assign mem_be    = r_mem_be;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;
   assign if_rdata  = r_if_rdata;
   assign if_valid  = r_if_valid;
   assign d_rdata   = r_d_rdata;
   assign d_valid   = r_d_valid;
   assign busy      = r_busy;

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Bench for cpu_mem_arbiter: memory model, transaction-level reference model,
// directed vector table, multi-cycle corner sequences and random traffic.
module tb_cpu_mem_arbiter;

   localparam int AW   = 32;
   localparam int DW   = 32;
   localparam int LAT  = 1;
   localparam int MAXS = 4;

   logic          clk = 1'b0;
   logic          reset, halt;
   logic          if_req, if_valid;
   logic [AW-1:0] if_addr;
   logic [DW-1:0] if_rdata;
   logic          d_req, d_we, d_valid;
   logic [3:0]    d_be;
   logic [AW-1:0] d_addr;
   logic [DW-1:0] d_wdata, d_rdata;
   logic          mem_en, mem_we, busy;
   logic [3:0]    mem_be;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata;

   always #5 clk = ~clk;

   cpu_mem_arbiter #(
      .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .MAX_DSTREAK(MAXS)
   ) dut (
      .clk(clk), .reset(reset), .halt(halt),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
      .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_valid(d_valid),
      .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
   );

   // Memory: read data appears LAT cycles after mem_en; idle cycles return a poison word.
   logic [31:0] mem [0:255];
   logic [31:0] rd_pipe [0:3];
   logic        mem_init;

   function automatic logic [31:0] init_word(int i);
      return 32'hC0DE_0000 | 32'(i);
   endfunction

   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
      end else if (mem_en && mem_we) begin
         for (int b = 0; b < 4; b++)
            if (mem_be[b]) mem[mem_addr[9:2]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      end
      rd_pipe[0] <= mem_en ? mem[mem_addr[9:2]] : 32'hDEAD_BEEF;
      for (int i = 1; i < 4; i++) rd_pipe[i] <= rd_pipe[i-1];
   end
   assign mem_rdata = rd_pipe[LAT-1];

   // Reference model: m_t is the cycle position inside the current access (0 = free).
   logic [31:0] ref_mem [0:255];
   int          m_t, m_streak;
   bit          m_d, m_we;
   logic [31:0] m_addr, m_wdata, m_rdata;
   logic [3:0]  m_be;
   int          cyc, n_chk, n_pass;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) $display("FAIL %s cyc=%0d act=%0h exp=%0h", nm, cyc, act, exp);
      else n_pass++;
   endtask

   task automatic cycle();
      if (reset) begin
         m_t = 0; m_streak = 0;
      end else if (m_t == 0) begin
         if (!halt && (if_req || d_req)) begin
            m_d = d_req && !(m_streak == MAXS && if_req);
            m_streak = m_d ? ((m_streak < MAXS) ? m_streak + 1 : MAXS) : 0;
            if (m_d) begin
               m_addr = d_addr; m_we = d_we; m_be = d_be; m_wdata = d_wdata;
            end else begin
               m_addr = if_addr; m_we = 1'b0; m_be = 4'hF;
            end
            m_rdata = ref_mem[m_addr[9:2]];
            if (m_we)
               for (int b = 0; b < 4; b++)
                  if (m_be[b]) ref_mem[m_addr[9:2]][b*8 +: 8] = m_wdata[b*8 +: 8];
            m_t = 1;
         end
      end else if (m_t == LAT + 2) begin
         m_t = 0;
      end else begin
         m_t++;
      end
      @(posedge clk); #1; cyc++;
      chk("ctl{en,we,busy,ifv,dv}", {mem_en, mem_we, busy, if_valid, d_valid},
          {m_t == 1, m_t == 1 && m_we, m_t != 0, m_t == LAT + 2 && !m_d, m_t == LAT + 2 && m_d});
      if (m_t == 1) begin
         chk("mem_addr", mem_addr, m_addr);
         chk("mem_be", mem_be, m_be);
         if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
      end
      if (m_t == LAT + 2 && !m_we)
         chk(m_d ? "d_rdata" : "if_rdata", m_d ? d_rdata : if_rdata, m_rdata);
   endtask

   typedef struct {
      bit          is_d;
      bit          we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp;
   } vec_t;
   vec_t tbl [10];

   task automatic do_txn(input vec_t v, input string nm);
      int start;
      bit got;
      start = cyc; got = 0;
      if (v.is_d) begin
         d_req = 1; d_we = v.we; d_be = v.be; d_addr = v.addr; d_wdata = v.wdata;
      end else begin
         if_req = 1; if_addr = v.addr;
      end
      for (int k = 0; k < 20 && !got; k++) begin
         cycle();
         if (v.is_d ? d_valid : if_valid) got = 1;
      end
      chk({nm, "_lat"}, 64'(cyc - start), 64'(LAT + 2));
      if (got && !v.we) chk({nm, "_data"}, v.is_d ? d_rdata : if_rdata, v.exp);
      d_req = 0; if_req = 0;
      cycle();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog cyc=%0d", cyc);
      $fatal(1);
   end

   initial begin
      int td, ti, start, nv;
      bit got;
      logic [6:0] ord;

      tbl[0] = '{0, 0, 4'h0, 32'h0000_0010, 32'h0,         32'hC0DE_0004};
      tbl[1] = '{1, 0, 4'h0, 32'h0000_0100, 32'h0,         32'hC0DE_0040};
      tbl[2] = '{1, 1, 4'h3, 32'h0000_0200, 32'hAABB_CCDD, 32'h0};
      tbl[3] = '{1, 0, 4'h0, 32'h0000_0200, 32'h0,         32'hC0DE_CCDD};
      tbl[4] = '{1, 1, 4'h0, 32'h0000_0204, 32'hFFFF_FFFF, 32'h0};
      tbl[5] = '{1, 0, 4'h0, 32'h0000_0204, 32'h0,         32'hC0DE_0081};
      tbl[6] = '{0, 0, 4'h0, 32'h0000_0200, 32'h0,         32'hC0DE_CCDD};
      tbl[7] = '{1, 1, 4'hC, 32'h0000_0208, 32'h1122_3344, 32'h0};
      tbl[8] = '{1, 0, 4'h0, 32'h0000_0208, 32'h0,         32'h1122_0082};
      tbl[9] = '{0, 0, 4'h0, 32'h0000_03FC, 32'h0,         32'hC0DE_00FF};

      for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
      cyc = 0; n_chk = 0; n_pass = 0; m_t = 0; m_streak = 0;
      m_d = 0; m_we = 0; m_addr = 0; m_wdata = 0; m_rdata = 0; m_be = 0;
      reset = 1; mem_init = 1; halt = 0;
      if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_be = 0; d_addr = 0; d_wdata = 0;

      cycle(); cycle();
      mem_init = 0;
      chk("rst_ctl", {mem_en, mem_we, busy, if_valid, d_valid, mem_be}, 0);
      chk("rst_addr_wdata", {mem_addr, mem_wdata}, 0);
      chk("rst_rdata", {if_rdata, d_rdata}, 0);
      reset = 0;
      cycle();

      for (int i = 0; i < 10; i++) do_txn(tbl[i], $sformatf("vec%0d", i));

      // Simultaneous requests: D first, IF one access period later.
      td = -100; ti = -1; start = cyc;
      d_req = 1; d_we = 0; d_be = 0; d_addr = 32'h100;
      if_req = 1; if_addr = 32'h10;
      for (int k = 0; k < 40 && (d_req || if_req); k++) begin
         cycle();
         if (d_valid) begin
            td = cyc; d_req = 0;
            chk("tie_d_data", d_rdata, 32'hC0DE_0040);
         end
         if (if_valid) begin
            ti = cyc; if_req = 0;
            chk("tie_if_data", if_rdata, 32'hC0DE_0004);
         end
      end
      chk("tie_d_lat", 64'(td - start), 64'(LAT + 2));
      chk("tie_gap", 64'(ti - td), 64'(LAT + 3));
      cycle();

      // Both held continuously: fetch is forced in after MAXS data grants.
      nv = 0; ord = 0;
      d_req = 1; d_we = 0; d_addr = 32'h100; if_req = 1; if_addr = 32'h10;
      for (int k = 0; k < 100 && nv < 7; k++) begin
         cycle();
         if (d_valid || if_valid) begin
            ord = {ord[5:0], d_valid};
            nv++;
         end
      end
      chk("streak_pattern", ord, 7'b1111011);
      d_req = 0; if_req = 0;
      cycle();

      // halt blocks new grants only; raised mid-access it does not stall completion.
      halt = 1; if_req = 1; if_addr = 32'h3FC;
      for (int k = 0; k < 5; k++) begin
         cycle();
         chk("halt_idle", {mem_en, busy}, 0);
      end
      halt = 0;
      cycle();
      chk("halt_rel_en", mem_en, 1);
      halt = 1;
      got = 0;
      for (int k = 0; k < 10 && !got; k++) begin
         cycle();
         if (if_valid) got = 1;
      end
      chk("halt_wait_done", got, 1);
      chk("halt_wait_data", if_rdata, 32'hC0DE_00FF);
      if_req = 0;
      cycle();
      halt = 0;

      // Reset during WAIT aborts the access without a pulse.
      d_req = 1; d_we = 0; d_addr = 32'h204;
      cycle(); cycle();
      chk("pre_rst_busy", busy, 1);
      reset = 1; d_req = 0;
      cycle();
      chk("rst_wait_busy", busy, 0);
      chk("rst_wait_valid", {if_valid, d_valid}, 0);
      reset = 0;
      for (int k = 0; k < 3; k++) begin
         cycle();
         chk("rst_no_pulse", {if_valid, d_valid}, 0);
      end
      do_txn(tbl[3], "post_rst");

      // Random traffic against the reference model.
      for (int k = 0; k < 1500; k++) begin
         if (!if_req && $urandom_range(0, 3) == 0) begin
            if_req = 1; if_addr = {22'b0, 8'($urandom_range(0, 255)), 2'b00};
         end
         if (!d_req && $urandom_range(0, 2) == 0) begin
            d_req = 1; d_we = 1'($urandom_range(0, 1)); d_be = 4'($urandom);
            d_addr = {22'b0, 8'($urandom_range(0, 255)), 2'b00}; d_wdata = $urandom;
         end
         halt = ($urandom_range(0, 9) == 0);
         cycle();
         if (if_valid) begin
            if ($urandom_range(0, 1) == 1) if_addr = {22'b0, 8'($urandom_range(0, 255)), 2'b00};
            else if_req = 0;
         end
         if (d_valid) begin
            if ($urandom_range(0, 1) == 1) begin
               d_we = 1'($urandom_range(0, 1)); d_be = 4'($urandom);
               d_addr = {22'b0, 8'($urandom_range(0, 255)), 2'b00}; d_wdata = $urandom;
            end else d_req = 0;
         end
      end
      halt = 0;
      for (int k = 0; k < 40 && (if_req || d_req || busy); k++) begin
         cycle();
         if (if_valid) if_req = 0;
         if (d_valid) d_req = 0;
      end
      chk("drain", {if_req, d_req, busy}, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
